// File: rtl/rot_reset_ctrl.sv
// RoT reset controller: stretches monitor violations into a held system reset, then waits for the reset-vector fetch.
// Optional cause/count logging is built only when RST_CAUSE_LOG_EN is defined.
module rot_reset_ctrl #(
    parameter int          NUM_SRC       = 4,
    parameter int          HOLD_CYCLES   = 8,
    parameter int          WAIT_TIMEOUT  = 64,
    parameter logic [15:0] RESET_HANDLER = 16'hFFFE,
    parameter int          CNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [15:0]        pc,
    input  logic [NUM_SRC-1:0] viol_req,
    input  logic               cause_clr,
    output logic               sys_reset,
    output logic               busy,
    output logic [NUM_SRC-1:0] rst_cause,
    output logic [CNT_W-1:0]   viol_cnt
);

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_HOLD    = 2'b01;
    localparam logic [1:0] ST_RELEASE = 2'b10;

    localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] TMO_INIT  = 8'(WAIT_TIMEOUT - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] tmo_q, tmo_d;
    logic       sys_reset_q, sys_reset_d;
    logic       busy_q, busy_d;

    logic any_req;
    logic at_handler;
    logic new_event;
    logic cause_update;

    assign any_req    = |viol_req;
    assign at_handler = (pc == RESET_HANDLER);

    // new_event marks every cycle that starts a reset window (fresh request or release timeout)
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tmo_d        = tmo_q;
        new_event    = 1'b0;
        cause_update = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d      = ST_HOLD;
                    cnt_d        = HOLD_INIT;
                    new_event    = 1'b1;
                    cause_update = 1'b1;
                end
            end
            ST_HOLD: begin
                cause_update = 1'b1;
                if (cnt_q == 8'd0) begin
                    state_d = ST_RELEASE;
                    tmo_d   = TMO_INIT;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_RELEASE: begin
                if (at_handler) begin
                    state_d = ST_IDLE;
                end else if (tmo_q == 8'd0) begin
                    state_d   = ST_HOLD;
                    cnt_d     = HOLD_INIT;
                    new_event = 1'b1;
                end else begin
                    tmo_d = tmo_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_HOLD;
                cnt_d   = HOLD_INIT;
            end
        endcase
    end

    always_comb begin
        sys_reset_d = (state_d == ST_HOLD);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            tmo_q       <= 8'd0;
            sys_reset_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            sys_reset_q <= sys_reset_d;
            busy_q      <= busy_d;
        end
    end

    assign sys_reset = sys_reset_q;
    assign busy      = busy_q;

`ifdef RST_CAUSE_LOG_EN
    logic [NUM_SRC-1:0] rst_cause_q, rst_cause_d;
    logic [CNT_W-1:0]   viol_cnt_q, viol_cnt_d;

    // Clear is applied first so a same-cycle event still records itself
    always_comb begin
        rst_cause_d = cause_clr ? '0 : rst_cause_q;
        if (cause_update) begin
            rst_cause_d = rst_cause_d | viol_req;
        end
        viol_cnt_d = cause_clr ? '0 : viol_cnt_q;
        if (new_event && (viol_cnt_d != '1)) begin
            viol_cnt_d = viol_cnt_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_cause_q <= '0;
            viol_cnt_q  <= '0;
        end else begin
            rst_cause_q <= rst_cause_d;
            viol_cnt_q  <= viol_cnt_d;
        end
    end

    assign rst_cause = rst_cause_q;
    assign viol_cnt  = viol_cnt_q;
`else
    logic [2:0] unused_log_sigs;
    assign unused_log_sigs = {cause_clr, new_event, cause_update};
    assign rst_cause       = '0;
    assign viol_cnt        = '0;
`endif

endmodule
